// File: rtl/gcd_stream_ctrl.sv
// Stream front-end for an external GCD core: queues operand pairs, short-circuits
// trivial pairs, issues the rest to the core and returns results with a timeout flag.
module gcd_stream_ctrl #(
   parameter int NBits   = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NBits-1:0] in_x,
   input  logic [NBits-1:0] in_y,
   output logic             gcd_start,
   output logic [NBits-1:0] gcd_xi,
   output logic [NBits-1:0] gcd_yi,
   input  logic             gcd_rdy,
   input  logic [NBits-1:0] gcd_xo,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NBits-1:0] out_gcd,
   output logic [NBits-1:0] out_x,
   output logic [NBits-1:0] out_y,
   output logic             out_err,
   output logic             busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

   logic [NBits-1:0] mem_x [DEPTH];
   logic [NBits-1:0] mem_y [DEPTH];
   logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [PW:0]      count_reg, count_next;
   logic             full, empty, push, pop;
   logic [NBits-1:0] head_x, head_y;

   state_t           state_reg, state_next;
   logic [NBits-1:0] x_reg, x_next, y_reg, y_next;
   logic [NBits-1:0] gcd_reg, gcd_next;
   logic             err_reg, err_next;
   logic [CW-1:0]    cnt_reg, cnt_next, cnt_inc;
   logic             rdy_q_reg, done;

   assign full   = (count_reg == (PW+1)'(DEPTH));
   assign empty  = (count_reg == '0);
   assign push   = in_valid && !full;
   assign pop    = (state_reg == IDLE) && !empty;
   assign head_x = mem_x[rd_ptr_reg];
   assign head_y = mem_y[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_x[wr_ptr_reg] <= in_x;
         mem_y[wr_ptr_reg] <= in_y;
      end
   end

   always_comb begin
      count_next = count_reg;
      if (push && !pop)
         count_next = count_reg + 1'b1;
      else if (pop && !push)
         count_next = count_reg - 1'b1;
   end

   // Only a fresh rising edge of the core's ready counts as completion.
   assign done    = (state_reg == WAIT) && gcd_rdy && !rdy_q_reg;
   assign cnt_inc = cnt_reg + CW'(1);

   always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      gcd_next   = gcd_reg;
      err_next   = err_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               x_next = head_x;
               y_next = head_y;
               if (head_x == '0 || head_y == '0) begin
                  gcd_next   = head_x + head_y;
                  err_next   = 1'b0;
                  state_next = OUT;
               end else if (head_x == head_y) begin
                  gcd_next   = head_x;
                  err_next   = 1'b0;
                  state_next = OUT;
               end else begin
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            if (done) begin
               gcd_next   = gcd_xo;
               err_next   = 1'b0;
               state_next = OUT;
            end else if (cnt_inc == CW'(TIMEOUT)) begin
               gcd_next   = '0;
               err_next   = 1'b1;
               state_next = OUT;
            end else begin
               cnt_next = cnt_inc;
            end
         end
         OUT: begin
            if (out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         x_reg      <= '0;
         y_reg      <= '0;
         gcd_reg    <= '0;
         err_reg    <= 1'b0;
         cnt_reg    <= '0;
         rdy_q_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         x_reg      <= x_next;
         y_reg      <= y_next;
         gcd_reg    <= gcd_next;
         err_reg    <= err_next;
         cnt_reg    <= cnt_next;
         rdy_q_reg  <= gcd_rdy;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   assign in_ready  = !full;
   assign gcd_start = (state_reg == ISSUE);
   assign gcd_xi    = (state_reg == ISSUE || state_reg == WAIT) ? x_reg : '0;
   assign gcd_yi    = (state_reg == ISSUE || state_reg == WAIT) ? y_reg : '0;
   assign out_valid = (state_reg == OUT);
   assign out_gcd   = gcd_reg;
   assign out_x     = x_reg;
   assign out_y     = y_reg;
   assign out_err   = err_reg;
   assign busy      = (state_reg != IDLE) || !empty;

endmodule
